lvds_word_packer: RTL and testbench

- Parametrised packer that gathers IN_W-bit LVDS samples into OUT_W = IN_W*RATIO-bit words for the capture FIFO.
- Adds selectable lane order, explicit flush of partial words with a lane count, an idle-timeout auto-flush, and ready/valid output with overflow reporting.
- Sits between the LVDS deserialiser and the capture FIFO write port. The input cannot stall, so there is no in_ready.

---
 rtl/lvds_word_packer_pkg.sv | 14 +
 rtl/lvds_word_packer_if.sv | 30 +++
 rtl/lvds_idle_timer.sv | 32 +++
 rtl/lvds_word_packer.sv | 112 +++++++++++
 tb/tb_lvds_word_packer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/lvds_word_packer_pkg.sv
// Shared widths and sizing helpers for the LVDS word packer slice.
// Defaults describe an 8-bit sample stream packed four samples per word.
package lvds_pkg;
  localparam int DEF_IN_W  = 8;
  localparam int DEF_RATIO = 4;

  function automatic int out_w(input int in_w, input int ratio);
    return in_w * ratio;
  endfunction

  function automatic int cnt_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction
endpackage

// File: rtl/lvds_word_packer_if.sv
// Sample-in / word-out bus of the packer: non-stallable input, ready/valid output.
// The master drives samples and out_ready; the slave (the packer) returns words.
interface lvds_word_packer_if
  import lvds_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int RATIO = DEF_RATIO
);
  localparam int OUT_W = out_w(IN_W, RATIO);
  localparam int CNT_W = cnt_w(RATIO);

  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_cnt;
  logic             overflow;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  out_valid, out_data, out_cnt, overflow
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output out_valid, out_data, out_cnt, overflow
  );
endinterface

// File: rtl/lvds_idle_timer.sv
// Counts idle cycles while a partial word is pending and pulses on the TIMEOUT-th one.
// The pulse is combinational so the flush lands in the same cycle the limit is reached.
module lvds_idle_timer #(
  parameter int TIMEOUT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_nonzero,
  input  logic in_valid,
  input  logic emit,
  output logic timeout_pulse
);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_idle;
  logic          w_idle_cyc;

  assign w_idle_cyc    = count_nonzero && !in_valid;
  // r_idle holds the idle cycles already seen, so this cycle is the TIMEOUT-th
  assign timeout_pulse = w_idle_cyc && (r_idle == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (clear || emit || !w_idle_cyc) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + TW'(1);
    end
  end
endmodule

// File: rtl/lvds_word_packer.sv
// Packs RATIO IN_W-bit samples into one word; 1 clk from completing sample to out_valid.
// Input never stalls: an emit while the held word is unaccepted is dropped and flagged.
module lvds_word_packer
  import lvds_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int RATIO     = DEF_RATIO,
  parameter int LSB_FIRST = 1,
  parameter int TIMEOUT   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  lvds_word_packer_if.slave  bus
);
  localparam int OUT_W = out_w(IN_W, RATIO);
  localparam int CNT_W = cnt_w(RATIO);

  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_acc;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_overflow;

  logic [CNT_W-1:0] w_lane;
  logic [OUT_W-1:0] w_word;
  logic [CNT_W-1:0] w_emit_cnt;
  logic             w_full;
  logic             w_flush;
  logic             w_emit;
  logic             w_load;
  logic             w_cnt_nz;
  logic             w_timeout;

  // w_word is the accumulator with this cycle's sample merged into its lane
  always_comb begin
    w_lane = (LSB_FIRST != 0) ? r_cnt : (CNT_W'(RATIO - 1) - r_cnt);
    w_word = r_acc;
    for (int l = 0; l < RATIO; l++) begin
      if (bus.in_valid && (w_lane == CNT_W'(l))) begin
        w_word[l*IN_W +: IN_W] = bus.in_data;
      end
    end
  end

  assign w_cnt_nz   = (r_cnt != '0);
  assign w_full     = bus.in_valid && (r_cnt == CNT_W'(RATIO - 1));
  assign w_flush    = bus.flush || w_timeout;
  assign w_emit     = w_full || (w_flush && (w_cnt_nz || bus.in_valid));
  assign w_emit_cnt = r_cnt + CNT_W'(bus.in_valid);
  assign w_load     = w_emit && (!r_out_valid || bus.out_ready);

  generate
    if (TIMEOUT > 0) begin : g_timer
      lvds_idle_timer #(
        .TIMEOUT(TIMEOUT)
      ) u_idle_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .count_nonzero(w_cnt_nz),
        .in_valid     (bus.in_valid),
        .emit         (w_emit),
        .timeout_pulse(w_timeout)
      );
    end else begin : g_no_timer
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_cnt   <= '0;
      r_overflow  <= 1'b0;
    end else if (clear) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_cnt   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_emit) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        r_cnt <= w_emit_cnt;
        r_acc <= w_word;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_word;
        r_out_cnt   <= w_emit_cnt;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_emit && !w_load) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_cnt   = r_out_cnt;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_lvds_word_packer.sv
// Drives three packer variants (LSB first, MSB first, LSB first with 16-cycle timeout)
// with directed and random samples, comparing against a sample-list reference model.
module tb_lvds_word_packer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       flush = 1'b0;
  logic       out_ready = 1'b1;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lvds_word_packer_if #(.IN_W(8), .RATIO(4)) if_a ();
  lvds_word_packer_if #(.IN_W(8), .RATIO(4)) if_b ();
  lvds_word_packer_if #(.IN_W(8), .RATIO(4)) if_c ();

  assign if_a.in_valid = in_valid;  assign if_a.in_data = in_data;
  assign if_a.flush = flush;        assign if_a.out_ready = out_ready;
  assign if_b.in_valid = in_valid;  assign if_b.in_data = in_data;
  assign if_b.flush = flush;        assign if_b.out_ready = out_ready;
  assign if_c.in_valid = in_valid;  assign if_c.in_data = in_data;
  assign if_c.flush = flush;        assign if_c.out_ready = out_ready;

  lvds_word_packer #(.IN_W(8), .RATIO(4), .LSB_FIRST(1), .TIMEOUT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_a));
  lvds_word_packer #(.IN_W(8), .RATIO(4), .LSB_FIRST(0), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_b));
  lvds_word_packer #(.IN_W(8), .RATIO(4), .LSB_FIRST(1), .TIMEOUT(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_c));

  logic        o_vld[3];
  logic [31:0] o_dat[3];
  logic [2:0]  o_cnt[3];
  logic        o_ovf[3];
  assign o_vld[0] = if_a.out_valid; assign o_dat[0] = if_a.out_data;
  assign o_cnt[0] = if_a.out_cnt;   assign o_ovf[0] = if_a.overflow;
  assign o_vld[1] = if_b.out_valid; assign o_dat[1] = if_b.out_data;
  assign o_cnt[1] = if_b.out_cnt;   assign o_ovf[1] = if_b.overflow;
  assign o_vld[2] = if_c.out_valid; assign o_dat[2] = if_c.out_data;
  assign o_cnt[2] = if_c.out_cnt;   assign o_ovf[2] = if_c.overflow;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each variant keeps the list of samples of the pending word
  logic [7:0]  m_s[3][4];
  int          m_n[3];
  int          m_idle[3];
  logic        m_vld[3];
  logic [31:0] m_dat[3];
  logic [2:0]  m_cnt[3];
  logic        m_ovf[3];

  function automatic bit lsbf(input int d);
    return d != 1;
  endfunction

  function automatic int tmo(input int d);
    return (d == 2) ? 16 : 0;
  endfunction

  function automatic logic [31:0] pack(input int d);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < m_n[d]; i++) begin
      int pos = lsbf(d) ? i : 3 - i;
      w = w | (32'(m_s[d][i]) << (8 * pos));
    end
    return w;
  endfunction

  task automatic model_reset(input int d);
    m_n[d] = 0; m_idle[d] = 0; m_vld[d] = 1'b0;
    m_dat[d] = 32'h0; m_cnt[d] = 3'd0; m_ovf[d] = 1'b0;
  endtask

  task automatic model_step(input int d);
    bit fl = flush;
    bit emit;
    if (tmo(d) > 0) begin
      if (m_n[d] > 0 && !in_valid) begin
        m_idle[d]++;
        if (m_idle[d] == tmo(d)) fl = 1'b1;
      end else begin
        m_idle[d] = 0;
      end
    end
    if (in_valid) begin
      m_s[d][m_n[d]] = in_data;
      m_n[d]++;
    end
    emit = (m_n[d] == 4) || (fl && m_n[d] > 0);
    if (emit) begin
      if (m_vld[d] && !out_ready) begin
        m_ovf[d] = 1'b1;
      end else begin
        m_vld[d] = 1'b1;
        m_dat[d] = pack(d);
        m_cnt[d] = 3'(m_n[d]);
      end
      m_n[d] = 0;
      m_idle[d] = 0;
    end else if (m_vld[d] && out_ready) begin
      m_vld[d] = 1'b0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n || clear) model_reset(d);
      else model_step(d);
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("model_vld%0d", d), 32'(o_vld[d]), 32'(m_vld[d]));
      chk($sformatf("model_dat%0d", d), o_dat[d], m_dat[d]);
      chk($sformatf("model_cnt%0d", d), 32'(o_cnt[d]), 32'(m_cnt[d]));
      chk($sformatf("model_ovf%0d", d), 32'(o_ovf[d]), 32'(m_ovf[d]));
    end
  end

  task automatic send(input bit v, input logic [7:0] d, input bit f);
    in_valid = v; in_data = d; flush = f;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 32'(if_a.out_valid), 32'h0);
    chk("rst_dat", if_a.out_data, 32'h0);
    chk("rst_cnt", 32'(if_a.out_cnt), 32'h0);
    chk("rst_ovf", 32'(if_a.overflow), 32'h0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    send(1, 8'h11, 0); send(1, 8'h22, 0); send(1, 8'h33, 0); send(1, 8'h44, 0);
    chk("full_vld", 32'(if_a.out_valid), 32'h1);
    chk("full_lsb", if_a.out_data, 32'h44332211);
    chk("full_cnt", 32'(if_a.out_cnt), 32'd4);
    chk("full_msb", if_b.out_data, 32'h11223344);

    send(1, 8'hAA, 0); send(1, 8'hBB, 0); send(0, 8'h00, 1);
    chk("flush_vld", 32'(if_a.out_valid), 32'h1);
    chk("flush_lsb", if_a.out_data, 32'h0000BBAA);
    chk("flush_cnt", 32'(if_a.out_cnt), 32'd2);
    chk("flush_msb", if_b.out_data, 32'hAABB0000);
    send(0, 8'h00, 1);
    chk("flush_empty", 32'(if_a.out_valid), 32'h0);

    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(1, 8'(i), 0);
    chk("ovf_vld", 32'(if_a.out_valid), 32'h1);
    chk("ovf_held", if_a.out_data, 32'h04030201);
    chk("ovf_flag", 32'(if_a.overflow), 32'h1);
    out_ready = 1'b1;
    send(0, 8'h00, 0);
    chk("ovf_drain", 32'(if_a.out_valid), 32'h0);
    chk("ovf_sticky", 32'(if_a.overflow), 32'h1);
    clear = 1'b1; send(0, 8'h00, 0); clear = 1'b0;
    chk("ovf_clear", 32'(if_a.overflow), 32'h0);

    send(1, 8'h10, 0); send(1, 8'h20, 0); send(1, 8'h30, 0);
    repeat (15) send(0, 8'h00, 0);
    chk("tmo_early", 32'(if_c.out_valid), 32'h0);
    send(0, 8'h00, 0);
    chk("tmo_vld", 32'(if_c.out_valid), 32'h1);
    chk("tmo_dat", if_c.out_data, 32'h00302010);
    chk("tmo_cnt", 32'(if_c.out_cnt), 32'd3);
    clear = 1'b1; send(0, 8'h00, 0); clear = 1'b0;

    send(1, 8'h55, 0); send(1, 8'h66, 0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_vld", 32'(if_a.out_valid), 32'h0);
    chk("mid_rst_dat", if_a.out_data, 32'h0);
    chk("mid_rst_ovf", 32'(if_a.overflow), 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) send(1, 8'(i), 0);
    chk("post_rst_dat", if_a.out_data, 32'h04030201);
    chk("post_rst_cnt", 32'(if_a.out_cnt), 32'd4);

    for (int blk = 0; blk < 8; blk++) begin
      int pv = (blk % 2 == 0) ? 7 : 1;
      for (int i = 0; i < 100; i++) begin
        out_ready = ($urandom_range(0, 9) < 6);
        clear     = ($urandom_range(0, 99) == 0);
        send($urandom_range(0, 9) < pv, 8'($urandom), $urandom_range(0, 9) == 0);
        clear = 1'b0;
      end
    end

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
